shift_deser: RTL and testbench

- Parametrised serial-to-parallel deserializer, successor to the 1-bit shift capture block.
- Accepts LANES bits per enabled beat and assembles WIDTH-bit words in a programmable bit order.
- Hands each finished word out through a valid/ready register with backpressure, so a word can be read out while the next one is being shifted in.
- Used in the forth_cpu serial front-ends, for example loading instruction words and UART/SPI byte assembly.

---
 rtl/shift_deser_if.sv | 29 ++
 rtl/shift_deser.sv | 90 +++++++++
 tb/tb_shift_deser.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_deser_if.sv
// Handshake bundle for shift_deser: beat input side, word output side and status.
// The slave modport is the deserializer; the master modport is whatever drives beats and takes words.
interface shift_deser_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
);
  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic             i_clear;
  logic             i_en;
  logic [LANES-1:0] i_data;
  logic             o_ready;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic [CW-1:0]    o_beat;
  logic             o_overrun;

  modport slave (
    input  i_clear, i_en, i_data, i_ready,
    output o_ready, o_valid, o_data, o_beat, o_overrun
  );

  modport master (
    output i_clear, i_en, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_beat, o_overrun
  );
endinterface

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer: LANES bits per beat into WIDTH-bit words,
// with a valid/ready output register so the next word can shift in while one is held.
module shift_deser #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  shift_deser_if.slave  bus
);
  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  // Handshakes: a beat moves when i_en && o_ready; a word moves when o_valid && i_ready.
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_beat;
  logic             r_valid;
  logic             r_ovr;

  logic             w_last;
  logic             w_ready;
  logic             w_acc;
  logic             w_fire;
  logic             w_done;
  logic [CW-1:0]    w_slot;
  logic [WIDTH-1:0] w_sr_next;

  assign w_last  = (r_beat == LAST_BEAT);
  // Only the completing beat can stall, and only while a word is still held.
  assign w_ready = !(r_valid && !bus.i_ready && w_last);
  assign w_acc   = bus.i_en && w_ready;
  assign w_fire  = r_valid && bus.i_ready;
  assign w_done  = w_acc && w_last;
  assign w_slot  = (MSB_FIRST != 0) ? (LAST_BEAT - r_beat) : r_beat;

  always_comb begin
    w_sr_next = r_sr;
    for (int k = 0; k < BEATS; k++) begin
      if (w_slot == CW'(k)) w_sr_next[k*LANES +: LANES] = bus.i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr    <= '0;
      r_data  <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (bus.i_clear) begin
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_sr <= w_sr_next;
        if (w_last) begin
          r_beat <= '0;
          r_data <= w_sr_next;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
      if (bus.i_en && !w_ready) r_ovr <= 1'b1;
      // A word completing in the same cycle as a read keeps o_valid high.
      if (w_done) r_valid <= 1'b1;
      else if (w_fire) r_valid <= 1'b0;
    end
  end

  assign bus.o_ready   = w_ready;
  assign bus.o_valid   = r_valid;
  assign bus.o_data    = r_data;
  assign bus.o_beat    = r_beat;
  assign bus.o_overrun = r_ovr;

`ifdef FORMAL
  a_beat_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_beat <= LAST_BEAT);
  a_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_valid && !bus.i_ready && !bus.i_clear) |=> (r_valid && $stable(r_data)));
  a_stall_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !w_ready |-> r_valid);
  a_overrun: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (bus.i_en && !w_ready && !bus.i_clear) |=> r_ovr);
`endif
endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: three configurations checked cycle by cycle against a
// word-level reference model, plus directed scenarios from the test plan.
module tb_shift_deser;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_deser_if #(.WIDTH(8),  .LANES(1)) bus0();
  shift_deser_if #(.WIDTH(16), .LANES(4)) bus1();
  shift_deser_if #(.WIDTH(8),  .LANES(8)) bus2();

  shift_deser #(.WIDTH(8),  .LANES(1), .MSB_FIRST(0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  shift_deser #(.WIDTH(16), .LANES(4), .MSB_FIRST(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
  shift_deser #(.WIDTH(8),  .LANES(8), .MSB_FIRST(0)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

  int n_cmp = 0;
  int n_err = 0;

  int cfg_w[3] = '{8, 16, 8};
  int cfg_l[3] = '{1, 4, 8};
  int cfg_m[3] = '{0, 1, 0};

  // Reference model: beats collected per word, held word, sticky overrun.
  int          m_cnt[3];
  logic        m_valid[3];
  logic [15:0] m_word[3];
  logic        m_ovr[3];
  logic [15:0] m_part[3][16];
  logic [15:0] exp_q[$];

  logic        obs_ready, obs_valid, obs_ovr;
  logic [15:0] obs_data;
  int          obs_beat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_cnt[d] = 0; m_valid[d] = 1'b0; m_word[d] = '0; m_ovr[d] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic sample(input int d);
    case (d)
      0: begin obs_ready = bus0.o_ready; obs_valid = bus0.o_valid; obs_data = 16'(bus0.o_data);
               obs_beat = int'(bus0.o_beat); obs_ovr = bus0.o_overrun; end
      1: begin obs_ready = bus1.o_ready; obs_valid = bus1.o_valid; obs_data = bus1.o_data;
               obs_beat = int'(bus1.o_beat); obs_ovr = bus1.o_overrun; end
      default: begin obs_ready = bus2.o_ready; obs_valid = bus2.o_valid; obs_data = 16'(bus2.o_data);
               obs_beat = int'(bus2.o_beat); obs_ovr = bus2.o_overrun; end
    endcase
  endtask

  task automatic drive(input int d, input logic clr, input logic en, input logic [15:0] data, input logic rdy);
    bus0.i_en = 1'b0; bus0.i_clear = 1'b0;
    bus1.i_en = 1'b0; bus1.i_clear = 1'b0;
    bus2.i_en = 1'b0; bus2.i_clear = 1'b0;
    case (d)
      0: begin bus0.i_clear = clr; bus0.i_en = en; bus0.i_data = data[0];   bus0.i_ready = rdy; end
      1: begin bus1.i_clear = clr; bus1.i_en = en; bus1.i_data = data[3:0]; bus1.i_ready = rdy; end
      default: begin bus2.i_clear = clr; bus2.i_en = en; bus2.i_data = data[7:0]; bus2.i_ready = rdy; end
    endcase
  endtask

  // One clock: drive after the falling edge, check just after, then advance the model.
  task automatic cycle(input int d, input logic clr, input logic en, input logic [15:0] data_in, input logic rdy);
    int beats;
    logic [15:0] data, w, popped;
    logic ready, fire, done;
    beats = cfg_w[d] / cfg_l[d];
    data  = data_in & 16'((1 << cfg_l[d]) - 1);
    @(negedge clk);
    drive(d, clr, en, data, rdy);
    #1;
    sample(d);
    ready = !(m_valid[d] && !rdy && (m_cnt[d] == beats - 1));
    check("ready", 32'(obs_ready), 32'(ready));
    check("valid", 32'(obs_valid), 32'(m_valid[d]));
    check("data", 32'(obs_data), 32'(m_word[d]));
    check("beat", 32'(obs_beat), 32'(m_cnt[d]));
    check("overrun", 32'(obs_ovr), 32'(m_ovr[d]));
    if (clr) begin
      m_cnt[d] = 0; m_valid[d] = 1'b0; m_ovr[d] = 1'b0;
      exp_q.delete();
    end else begin
      fire = m_valid[d] && rdy;
      done = en && ready && (m_cnt[d] == beats - 1);
      if (fire) begin
        if (exp_q.size() == 0) check("sb_empty", 32'(exp_q.size()), 32'd1);
        else begin
          popped = exp_q.pop_front();
          check("sb_word", 32'(obs_data), 32'(popped));
        end
      end
      if (en && ready) begin
        m_part[d][m_cnt[d]] = data;
        if (m_cnt[d] == beats - 1) begin
          w = '0;
          for (int k = 0; k < beats; k++)
            w = w | (m_part[d][k] << (cfg_m[d] != 0 ? (beats - 1 - k) * cfg_l[d] : k * cfg_l[d]));
          m_word[d] = w;
          exp_q.push_back(w);
          m_cnt[d] = 0;
        end else begin
          m_cnt[d]++;
        end
      end else if (en) begin
        m_ovr[d] = 1'b1;
      end
      if (done) m_valid[d] = 1'b1;
      else if (fire) m_valid[d] = 1'b0;
    end
  endtask

  task automatic random_run(input int d, input int n);
    for (int i = 0; i < n; i++)
      cycle(d, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            16'($urandom), $urandom_range(0, 2) != 0);
  endtask

  logic [7:0] pat_a, pat_b;

  initial begin
    pat_a = 8'b0100_1101;
    pat_b = 8'b1011_0010;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 1'b1);
    bus0.i_ready = 1'b1; bus1.i_ready = 1'b1; bus2.i_ready = 1'b1;
    bus0.i_data = '0; bus1.i_data = '0; bus2.i_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset / idle state on all three instances.
    for (int d = 0; d < 3; d++) cycle(d, 1'b0, 1'b0, 16'h0, 1'b1);
    check("idle_ready", 32'(obs_ready), 32'd1);

    // LSB serial word 8'h4D, then o_valid drops one cycle later.
    for (int k = 0; k < 8; k++) cycle(0, 1'b0, 1'b1, 16'(pat_a[k]), 1'b1);
    cycle(0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("lsb_valid", 32'(obs_valid), 32'd1);
    check("lsb_word", 32'(obs_data), 32'h4D);
    cycle(0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("lsb_drop", 32'(obs_valid), 32'd0);

    // Asynchronous reset mid-word at beat 5.
    for (int k = 0; k < 5; k++) cycle(0, 1'b0, 1'b1, 16'(k & 1), 1'b1);
    @(negedge clk);
    bus0.i_en = 1'b0;
    #1; sample(0);
    check("pre_rst_beat", 32'(obs_beat), 32'd5);
    rst_n = 1'b0;
    #1; sample(0);
    check("async_beat", 32'(obs_beat), 32'd0);
    check("async_data", 32'(obs_data), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Backpressure: hold 8'h4D, 7 beats accepted, 8th stalls and is dropped.
    for (int k = 0; k < 8; k++) cycle(0, 1'b0, 1'b1, 16'(pat_a[k]), 1'b0);
    for (int k = 0; k < 7; k++) cycle(0, 1'b0, 1'b1, 16'(pat_b[k]), 1'b0);
    cycle(0, 1'b0, 1'b1, 16'(pat_b[7]), 1'b0);
    check("stall_ready", 32'(obs_ready), 32'd0);
    check("stall_beat", 32'(obs_beat), 32'd7);
    check("stall_data", 32'(obs_data), 32'h4D);
    cycle(0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("ovr_set", 32'(obs_ovr), 32'd1);
    check("ovr_beat", 32'(obs_beat), 32'd7);
    cycle(0, 1'b0, 1'b1, 16'(pat_b[7]), 1'b1);
    check("release_ready", 32'(obs_ready), 32'd1);
    cycle(0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("b2b_valid", 32'(obs_valid), 32'd1);
    check("b2b_word", 32'(obs_data), 32'hB2);

    // Overrun again, then clear with a beat offered in the same cycle.
    for (int k = 0; k < 8; k++) cycle(0, 1'b0, 1'b1, 16'(pat_a[k]), 1'b0);
    cycle(0, 1'b1, 1'b1, 16'h1, 1'b0);
    check("pre_clr_ovr", 32'(obs_ovr), 32'd1);
    cycle(0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("clr_ovr", 32'(obs_ovr), 32'd0);
    check("clr_valid", 32'(obs_valid), 32'd0);
    check("clr_beat", 32'(obs_beat), 32'd0);
    check("clr_data_kept", 32'(obs_data), 32'hB2);
    random_run(0, 400);
    exp_q.delete();

    // MSB multi-lane: A,B,C,D -> 16'hABCD, o_beat steps 1,2,3,0.
    cycle(1, 1'b1, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1, 1'b0, 1'b1, 16'(10 + k), 1'b1);
    cycle(1, 1'b0, 1'b0, 16'h0, 1'b1);
    check("msb_word", 32'(obs_data), 32'hABCD);
    check("msb_valid", 32'(obs_valid), 32'd1);
    random_run(1, 400);
    exp_q.delete();

    // Full-rate stream with LANES == WIDTH.
    cycle(2, 1'b1, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(2, 1'b0, 1'b1, 16'(i + 1), 1'b1);
      if (i > 0) begin
        check("stream_valid", 32'(obs_valid), 32'd1);
        check("stream_data", 32'(obs_data), 32'(i));
        check("stream_beat", 32'(obs_beat), 32'd0);
      end
    end
    check("stream_ovr", 32'(obs_ovr), 32'd0);
    random_run(2, 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
